uart_tx_arbiter: RTL
====================

Name: uart_tx_arbiter

Overview:
- Shares one UART transmitter between NUM_REQ requesters, e.g. sensor logger, debug console and BLE bridge on the smartwatch.
- Uses round-robin packet arbitration. A winner keeps the transmitter until its last byte, a burst cap, or a watchdog abort.
- Drives the transmitter's data-valid/byte inputs and consumes its active/done status.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- MAX_BURST, 16, max bytes per grant before forced release (1..255).
- WATCHDOG_CLKS, 4096, max cycles in WAIT_DONE before abort; set ≥ 10*CLKS_PER_BIT + margin.

Ports:
- clk  in  1  system clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- i_Req  in  NUM_REQ  per-requester "byte available"; held high while byte valid.
- i_Req_Byte  in  8*NUM_REQ  byte of requester k at bits [8k+7:8k].
- i_Req_Last  in  NUM_REQ  byte presented is last of packet.
- o_Ack  out  NUM_REQ  one-cycle pulse: byte of requester k consumed.
- o_Grant  out  NUM_REQ  one-hot current owner; 0 when idle.
- o_TX_DV  out  1  one-cycle start pulse to UART transmitter.
- o_TX_Byte  out  8  byte to transmit, valid with o_TX_DV.
- i_TX_Active  in  1  transmitter busy.
- i_TX_Done  in  1  one-cycle pulse at end of stop bit.
- o_Timeout_Err  out  1  one-cycle pulse on watchdog abort.

Behaviour:
- States: IDLE, SEND, WAIT_DONE. All outputs registered.
- Reset:
  - state=IDLE, rr_ptr=0, burst_cnt=0, wd_cnt=0.
  - o_Ack=0, o_Grant=0, o_TX_DV=0, o_TX_Byte=0, o_Timeout_Err=0.
- Reset mid-frame: the transmitter is not reset and may finish its frame. A stray i_TX_Done seen in IDLE is ignored.
- IDLE, cycle n:
  - If any i_Req is high and i_TX_Active=0, pick the first k with i_Req[k]=1 scanning rr_ptr, rr_ptr+1, … mod NUM_REQ.
  - In cycle n+1: o_Grant=onehot(k), o_TX_DV=1, o_TX_Byte=i_Req_Byte[k] as sampled in cycle n, o_Ack[k]=1, burst_cnt=1, last flag latched.
  - Next state is SEND.
  - If i_TX_Active=1, stay in IDLE.
- SEND: lasts exactly one cycle (the o_TX_DV cycle), then WAIT_DONE with wd_cnt=0.
- Byte handoff: requester may change its byte/last from the cycle after o_Ack.
- WAIT_DONE:
  - wd_cnt increments each cycle.
  - On i_TX_Done in cycle m, continue if: latched last=0, burst_cnt<MAX_BURST, and i_Req[k]=1 in cycle m.
    - Continue: cycle m+1 is SEND with the new byte and o_Ack[k]; burst_cnt increments.
    - Otherwise release: cycle m+1 is IDLE, o_Grant=0, rr_ptr=(k+1) mod NUM_REQ, burst_cnt=0.
  - Earliest new grant after release is cycle m+2 (one idle gap).
  - If wd_cnt reaches WATCHDOG_CLKS-1 with no done: pulse o_Timeout_Err, release as above, return to IDLE.
- Released without last: the requester's packet is interrupted. It re-arbitrates with no priority over others.
- Ignored inputs:
  - i_Req of non-owners while a grant is held.
  - i_Req_Last of non-owners.
  - i_TX_Done outside WAIT_DONE.
- rr_ptr advances only on release; ties are resolved purely by rotation from rr_ptr.
- o_Ack and o_TX_DV are never high more than one cycle per byte. At most one bit of o_Ack/o_Grant is set.

Test Plan:
1. Single packet: req1 sends 0xA5, 0x5A(last); transmitter model pulses done 20 cycles after DV.
   - Expect 2 DV pulses with bytes A5, 5A and 2 o_Ack[1] pulses.
   - Expect o_Grant=0010 throughout, then 0; rr_ptr=2.
2. Contention: req0, req2, req3 all request 1-byte packets in the same IDLE cycle with rr_ptr=0.
   - Expect grant order 0, 2, 3 and one idle cycle between releases.
   - A repeated req0 request is served after req3.
3. Burst cap: MAX_BURST=4; req2 streams 10 bytes with no last while req0 is pending.
   - Expect 4 bytes from req2, release, req0 served, then req2 resumes.
4. Watchdog: WATCHDOG_CLKS=64 and the model never pulses done.
   - Expect o_Timeout_Err one cycle at cycle 63 of WAIT_DONE, then o_Grant=0 and IDLE.
   - The next requester is served normally.
5. Reset mid-packet: assert rst in WAIT_DONE during a 3-byte packet.
   - Expect all outputs 0 the next cycle.
   - A late i_TX_Done is ignored; a fresh request is granted from rr_ptr=0.
6. Busy transmitter: hold i_TX_Active=1 with i_Req[0]=1.
   - Expect no DV while active. DV fires the cycle after active drops.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin packet arbiter sharing one UART transmitter between NUM_REQ requesters.
// A grant lasts until the packet's last byte, a burst cap, or a watchdog abort.
module uart_tx_arbiter #(
    parameter int unsigned NUM_REQ       = 4,
    parameter int unsigned MAX_BURST     = 16,
    parameter int unsigned WATCHDOG_CLKS = 4096
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     i_Req,
    input  logic [8*NUM_REQ-1:0]   i_Req_Byte,
    input  logic [NUM_REQ-1:0]     i_Req_Last,
    output logic [NUM_REQ-1:0]     o_Ack,
    output logic [NUM_REQ-1:0]     o_Grant,
    output logic                   o_TX_DV,
    output logic [7:0]             o_TX_Byte,
    input  logic                   i_TX_Active,
    input  logic                   i_TX_Done,
    output logic                   o_Timeout_Err
);
    localparam int unsigned PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned BURST_W = 8;
    localparam int unsigned WD_W    = (WATCHDOG_CLKS > 1) ? $clog2(WATCHDOG_CLKS) : 1;

    typedef enum logic [1:0] {IDLE, SEND, WAIT_DONE} state_t;

    state_t               state_q, state_d;
    logic [PTR_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0]     owner_q, owner_d;
    logic [BURST_W-1:0]   burst_q, burst_d;
    logic [WD_W-1:0]      wd_q, wd_d;
    logic                 last_q, last_d;
    logic [NUM_REQ-1:0]   ack_d, grant_d;
    logic                 dv_d, tout_d;
    logic [7:0]           byte_d;
    logic                 pick_found;
    logic [PTR_W-1:0]     pick_idx;
    logic [PTR_W-1:0]     cand;
    logic                 do_release;

    function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] p);
        return (32'(p) == NUM_REQ - 1) ? '0 : p + PTR_W'(1);
    endfunction

    function automatic logic [NUM_REQ-1:0] onehot(input logic [PTR_W-1:0] k);
        return NUM_REQ'(1) << k;
    endfunction

    function automatic logic [7:0] byte_of(input logic [8*NUM_REQ-1:0] bytes,
                                           input logic [PTR_W-1:0] k);
        return bytes[8*int'(k) +: 8];
    endfunction

    // First requesting index, scanning upward from rr_ptr with wraparound.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = rr_ptr_q;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (!pick_found && i_Req[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
            cand = wrap_inc(cand);
        end
    end

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        owner_d    = owner_q;
        burst_d    = burst_q;
        wd_d       = wd_q;
        last_d     = last_q;
        ack_d      = '0;
        grant_d    = o_Grant;
        dv_d       = 1'b0;
        byte_d     = o_TX_Byte;
        tout_d     = 1'b0;
        do_release = 1'b0;

        case (state_q)
            IDLE: begin
                if (pick_found && !i_TX_Active) begin
                    state_d = SEND;
                    owner_d = pick_idx;
                    grant_d = onehot(pick_idx);
                    ack_d   = onehot(pick_idx);
                    dv_d    = 1'b1;
                    byte_d  = byte_of(i_Req_Byte, pick_idx);
                    burst_d = BURST_W'(1);
                    last_d  = i_Req_Last[pick_idx];
                end
            end
            SEND: begin
                state_d = WAIT_DONE;
                wd_d    = '0;
            end
            WAIT_DONE: begin
                wd_d = wd_q + WD_W'(1);
                if (i_TX_Done) begin
                    // Keep the transmitter only for an unfinished packet under the burst cap.
                    if (!last_q && (32'(burst_q) < MAX_BURST) && i_Req[owner_q]) begin
                        state_d = SEND;
                        ack_d   = onehot(owner_q);
                        dv_d    = 1'b1;
                        byte_d  = byte_of(i_Req_Byte, owner_q);
                        burst_d = burst_q + BURST_W'(1);
                        last_d  = i_Req_Last[owner_q];
                    end else begin
                        do_release = 1'b1;
                    end
                end else if (32'(wd_q) == WATCHDOG_CLKS - 1) begin
                    do_release = 1'b1;
                    tout_d     = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (do_release) begin
            state_d  = IDLE;
            grant_d  = '0;
            rr_ptr_d = wrap_inc(owner_q);
            burst_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            rr_ptr_q      <= '0;
            owner_q       <= '0;
            burst_q       <= '0;
            wd_q          <= '0;
            last_q        <= 1'b0;
            o_Ack         <= '0;
            o_Grant       <= '0;
            o_TX_DV       <= 1'b0;
            o_TX_Byte     <= '0;
            o_Timeout_Err <= 1'b0;
        end else begin
            state_q       <= state_d;
            rr_ptr_q      <= rr_ptr_d;
            owner_q       <= owner_d;
            burst_q       <= burst_d;
            wd_q          <= wd_d;
            last_q        <= last_d;
            o_Ack         <= ack_d;
            o_Grant       <= grant_d;
            o_TX_DV       <= dv_d;
            o_TX_Byte     <= byte_d;
            o_Timeout_Err <= tout_d;
        end
    end
endmodule
